sha2_compress_core: RTL and testbench

Sequential SHA-2 compression engine that processes one message block per `start` into an updated chaining value, in SHA-256 or SHA-512 mode selected per block. It generalises the team's combinational single-round SHA-2 datapath into a full iterated core. That core has an internal message schedule, a K-constant ROM, a configurable number of rounds per clock and the final feed-forward addition. It sits between the padding/block buffer (upstream) and the digest register file (downstream).

---
 rtl/sha2_compress_core.sv | 199 +++++++++++++++++++
 tb/tb_sha2_compress_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_compress_core.sv
// Iterated SHA-256/SHA-512 compression core: 16-word schedule window, shared 80x64 K ROM,
// ROUNDS_PER_CYCLE chained rounds per clock and final feed-forward addition.
module sha2_compress_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [1023:0] block_in,
  input  logic [511:0]  hash_in,
  output logic          busy,
  output logic          done,
  output logic [511:0]  hash_out
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [63:0] K_ROM [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] bsig0(input logic m, input logic [63:0] x);
    if (m) return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
    return {32'h0, rotr32(x[31:0], 2) ^ rotr32(x[31:0], 13) ^ rotr32(x[31:0], 22)};
  endfunction

  function automatic logic [63:0] bsig1(input logic m, input logic [63:0] x);
    if (m) return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
    return {32'h0, rotr32(x[31:0], 6) ^ rotr32(x[31:0], 11) ^ rotr32(x[31:0], 25)};
  endfunction

  function automatic logic [63:0] ssig0(input logic m, input logic [63:0] x);
    if (m) return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    return {32'h0, rotr32(x[31:0], 7) ^ rotr32(x[31:0], 18) ^ (x[31:0] >> 3)};
  endfunction

  function automatic logic [63:0] ssig1(input logic m, input logic [63:0] x);
    if (m) return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    return {32'h0, rotr32(x[31:0], 17) ^ rotr32(x[31:0], 19) ^ (x[31:0] >> 10)};
  endfunction

  function automatic logic [63:0] k_at(input logic [6:0] i);
    return (i < 7'd80) ? K_ROM[i] : '0;
  endfunction

  state_t       state_q, state_d;
  logic         mode_q;
  logic [6:0]   t_q;
  logic [63:0]  w_q  [16];
  logic [63:0]  h_q  [8];
  logic [63:0]  wv_q [8];

  logic         load_en, round_en, final_en, last_step;
  logic [6:0]   n_rounds;
  logic [63:0]  lane_mask;
  logic [63:0]  ext    [16+R];
  logic [63:0]  v_next [8];
  logic [63:0]  t1, t2, kfull, kw;
  logic [6:0]   idx;
  logic [63:0]  blk_lane [16];
  logic [63:0]  hin_lane [8];
  logic [63:0]  sum_lane [8];
  logic [511:0] hash512, hash_sum;
  logic [255:0] hash256;

  assign lane_mask = mode_q ? '1 : 64'h0000_0000_ffff_ffff;
  assign n_rounds  = mode_q ? 7'd80 : 7'd64;
  assign last_step = ((t_q + 7'(R)) == n_rounds);

  for (genvar gi = 0; gi < 16; gi++) begin : g_blk
    assign blk_lane[gi] = mode ? block_in[1023-64*gi -: 64] : {32'h0, block_in[511-32*gi -: 32]};
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_hash
    assign hin_lane[gi] = mode ? hash_in[511-64*gi -: 64] : {32'h0, hash_in[255-32*gi -: 32]};
    assign sum_lane[gi] = (h_q[gi] + wv_q[gi]) & lane_mask;
    assign hash512[511-64*gi -: 64] = sum_lane[gi];
    assign hash256[255-32*gi -: 32] = sum_lane[gi][31:0];
  end

  assign hash_sum = mode_q ? hash512 : {256'h0, hash256};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: if (last_step) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state_q == S_IDLE) && start;
    round_en = (state_q == S_ROUND);
    final_en = (state_q == S_FINAL);
  end

  // Schedule words beyond the window are chained so later rounds in the same cycle see them.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int unsigned j = 0; j < R; j++)
      ext[16+j] = (ssig1(mode_q, ext[14+j]) + ext[9+j] + ssig0(mode_q, ext[1+j]) + ext[j]) & lane_mask;
    for (int unsigned i = 0; i < 8; i++) v_next[i] = wv_q[i];
    t1 = '0; t2 = '0; kfull = '0; kw = '0; idx = '0;
    for (int unsigned j = 0; j < R; j++) begin
      idx   = t_q + 7'(j);
      kfull = k_at(idx);
      kw    = mode_q ? kfull : {32'h0, kfull[63:32]};
      t1 = (v_next[7] + bsig1(mode_q, v_next[4])
            + ((v_next[4] & v_next[5]) ^ (~v_next[4] & v_next[6])) + kw + ext[j]) & lane_mask;
      t2 = (bsig0(mode_q, v_next[0])
            + ((v_next[0] & v_next[1]) ^ (v_next[0] & v_next[2]) ^ (v_next[1] & v_next[2]))) & lane_mask;
      v_next[7] = v_next[6];
      v_next[6] = v_next[5];
      v_next[5] = v_next[4];
      v_next[4] = (v_next[3] + t1) & lane_mask;
      v_next[3] = v_next[2];
      v_next[2] = v_next[1];
      v_next[1] = v_next[0];
      v_next[0] = (t1 + t2) & lane_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      t_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hash_out <= '0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        h_q[i]  <= '0;
        wv_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (load_en) begin
        mode_q <= mode;
        t_q    <= '0;
        busy   <= 1'b1;
        for (int unsigned i = 0; i < 16; i++) w_q[i] <= blk_lane[i];
        for (int unsigned i = 0; i < 8; i++) begin
          h_q[i]  <= hin_lane[i];
          wv_q[i] <= hin_lane[i];
        end
      end else if (round_en) begin
        t_q <= t_q + 7'(R);
        for (int unsigned i = 0; i < 16; i++) w_q[i] <= ext[i+R];
        for (int unsigned i = 0; i < 8; i++) wv_q[i] <= v_next[i];
      end else if (final_en) begin
        hash_out <= hash_sum;
        done     <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha2_compress_core.sv
// Directed + randomized bench for sha2_compress_core (R=1 and R=16 instances)
// against a full-schedule SHA-2 reference model.
module tb_sha2_compress_core;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start16 = 1'b0;
  logic          mode = 1'b0;
  logic [1023:0] block_in = '0;
  logic [511:0]  hash_in = '0;
  logic          busy, done, busy16, done16;
  logic [511:0]  hash_out, hash_out16;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  sha2_compress_core #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .block_in(block_in),
    .hash_in(hash_in), .busy(busy), .done(done), .hash_out(hash_out));

  sha2_compress_core #(.ROUNDS_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .block_in(block_in),
    .hash_in(hash_in), .busy(busy16), .done(done16), .hash_out(hash_out16));

  localparam longint unsigned KT [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] IV256 = {256'h0,
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19};
  localparam logic [1023:0] ABC512   = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [1023:0] ABC256   = {512'h0, 32'h61626380, 448'h0, 32'h18};
  localparam logic [1023:0] EMPTY256 = {512'h0, 32'h80000000, 480'h0};
  localparam logic [511:0] DIG_ABC256 = {256'h0,
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
  localparam logic [511:0] DIG_EMPTY256 = {256'h0,
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
  localparam logic [511:0] DIG_ABC512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  function automatic longint unsigned ror(input longint unsigned x, input int unsigned n,
                                          input int unsigned ws);
    if (ws == 64) return (x >> n) | (x << (64 - n));
    return ((x >> n) | (x << (32 - n))) & 64'hffff_ffff;
  endfunction

  // Textbook compression: full 64/80-entry schedule, then the round loop, then feed-forward.
  function automatic logic [511:0] ref_compress(input bit m, input logic [1023:0] blk,
                                                input logic [511:0] hin);
    longint unsigned w [80];
    longint unsigned hv [8];
    longint unsigned v [8];
    longint unsigned msk, s0, s1, t1, t2, k, x, y;
    int unsigned nr, ws;
    logic [511:0] r;
    msk = m ? 64'hffff_ffff_ffff_ffff : 64'hffff_ffff;
    nr  = m ? 80 : 64;
    ws  = m ? 64 : 32;
    r   = '0;
    for (int i = 0; i < 16; i++)
      w[i] = m ? 64'(blk >> (64 * (15 - i))) : {32'h0, 32'(blk >> (32 * (15 - i)))};
    for (int i = 0; i < 8; i++)
      hv[i] = m ? 64'(hin >> (64 * (7 - i))) : {32'h0, 32'(hin >> (32 * (7 - i)))};
    for (int i = 16; i < 80; i++) begin
      x = w[i-15];
      y = w[i-2];
      s0 = m ? (ror(x, 1, 64) ^ ror(x, 8, 64) ^ (x >> 7)) : (ror(x, 7, 32) ^ ror(x, 18, 32) ^ (x >> 3));
      s1 = m ? (ror(y, 19, 64) ^ ror(y, 61, 64) ^ (y >> 6)) : (ror(y, 17, 32) ^ ror(y, 19, 32) ^ (y >> 10));
      w[i] = (s1 + w[i-7] + s0 + w[i-16]) & msk;
    end
    for (int i = 0; i < 8; i++) v[i] = hv[i];
    for (int t = 0; t < int'(nr); t++) begin
      k  = m ? KT[t] : (KT[t] >> 32);
      s1 = m ? (ror(v[4], 14, ws) ^ ror(v[4], 18, ws) ^ ror(v[4], 41, ws))
             : (ror(v[4], 6, ws) ^ ror(v[4], 11, ws) ^ ror(v[4], 25, ws));
      s0 = m ? (ror(v[0], 28, ws) ^ ror(v[0], 34, ws) ^ ror(v[0], 39, ws))
             : (ror(v[0], 2, ws) ^ ror(v[0], 13, ws) ^ ror(v[0], 22, ws));
      t1 = (v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w[t]) & msk;
      t2 = (s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & msk;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = (v[3] + t1) & msk;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = (t1 + t2) & msk;
    end
    for (int i = 0; i < 8; i++) begin
      if (m) r = r | (512'((hv[i] + v[i]) & msk) << (64 * (7 - i)));
      else   r = r | (512'((hv[i] + v[i]) & msk) << (32 * (7 - i)));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one block on the selected instance and wait (bounded) for its done pulse.
  task automatic run_block(input bit sel, input bit m, input logic [1023:0] blk,
                           input logic [511:0] hin, output int unsigned lat,
                           output logic [511:0] res, output logic busy0);
    @(posedge clk); #1;
    mode = m; block_in = blk; hash_in = hin;
    if (sel) start16 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start16 = 1'b0;
    busy0 = sel ? busy16 : busy;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(sel ? done16 : done) && lat < 200);
    res = sel ? hash_out16 : hash_out;
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] b = '0;
    for (int i = 0; i < 32; i++) b = {b[991:0], 32'($urandom)};
    return b;
  endfunction

  initial begin : main
    int unsigned lat, lat2, dones;
    logic [511:0] res, hin, exp_res;
    logic [1023:0] blk;
    logic busy0;
    bit m;

    #12;
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_done", 512'(done), 512'(0));
    chk("reset_hash", hash_out, '0);
    chk("reset_hash16", hash_out16, '0);
    @(negedge clk); rst_n = 1'b1;

    run_block(0, 0, ABC256, IV256, lat, res, busy0);
    chk("abc256_busy", 512'(busy0), 512'(1));
    chk("abc256_lat", 512'(lat), 512'(65));
    chk("abc256_hash", res, DIG_ABC256);
    chk("abc256_busy_at_done", 512'(busy), 512'(0));
    @(posedge clk); #1;
    chk("abc256_done_pulse", 512'(done), 512'(0));
    chk("abc256_hold", hash_out, DIG_ABC256);

    run_block(0, 1, ABC512, IV512, lat, res, busy0);
    chk("abc512_lat", 512'(lat), 512'(81));
    chk("abc512_hash", res, DIG_ABC512);

    run_block(1, 1, ABC512, IV512, lat, res, busy0);
    chk("abc512_r16_lat", 512'(lat), 512'(6));
    chk("abc512_r16_hash", res, DIG_ABC512);
    run_block(1, 0, ABC256, IV256, lat, res, busy0);
    chk("abc256_r16_lat", 512'(lat), 512'(5));
    chk("abc256_r16_hash", res, DIG_ABC256);

    run_block(0, 0, EMPTY256, IV256, lat, res, busy0);
    chk("empty256_hash", res, DIG_EMPTY256);

    for (int n = 0; n < 8; n++) begin
      m = 1'($urandom);
      blk = rand_blk();
      hin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_res = ref_compress(m, blk, hin);
      run_block(n[0], m, blk, hin, lat, res, busy0);
      chk(n[0] ? "rand_r16_hash" : "rand_r1_hash", res, exp_res);
      chk(n[0] ? "rand_r16_lat" : "rand_r1_lat", 512'(lat),
          512'(n[0] ? (m ? 6 : 5) : (m ? 81 : 65)));
    end

    // Start pulses and input changes while busy must not disturb the running block.
    @(posedge clk); #1;
    mode = 0; block_in = ABC256; hash_in = IV256; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; lat++; end
    start = 1'b1; mode = 1'b1; block_in = rand_blk(); hash_in = ~IV256;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("isolate_lat", 512'(lat), 512'(65));
    chk("isolate_hash", hash_out, DIG_ABC256);
    dones = 0;
    for (int i = 0; i < 100; i++) begin @(posedge clk); #1; if (done) dones++; end
    chk("isolate_no_extra_done", 512'(dones), 512'(0));

    // Back-to-back: second start raised during the first done cycle.
    run_block(0, 0, ABC256, IV256, lat, res, busy0);
    chk("b2b_first_hash", res, DIG_ABC256);
    mode = 1'b1; block_in = ABC512; hash_in = IV512; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", 512'(busy), 512'(1));
    lat2 = 0;
    do begin @(posedge clk); #1; lat2++; end while (!done && lat2 < 200);
    chk("b2b_second_lat", 512'(lat2), 512'(81));
    chk("b2b_second_hash", hash_out, DIG_ABC512);

    // Reset during round 30 discards the block.
    @(posedge clk); #1;
    mode = 1'b1; block_in = ABC512; hash_in = IV512; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 512'(busy), 512'(0));
    chk("midreset_done", 512'(done), 512'(0));
    chk("midreset_hash", hash_out, '0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done || busy) dones++; end
    chk("midreset_quiet", 512'(dones), 512'(0));
    @(negedge clk); rst_n = 1'b1;
    run_block(0, 1, ABC512, IV512, lat, res, busy0);
    chk("post_reset_lat", 512'(lat), 512'(81));
    chk("post_reset_hash", res, DIG_ABC512);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
